// File: rtl/caf_pkg.sv
// Shared constants for the CAF lag-sweep sequencer: FSM state encoding and buffer read latency.
package caf_pkg;

  localparam int STATE_BITS = 3;

  localparam logic [STATE_BITS-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_BITS-1:0] S_ISSUE  = 3'd1;
  localparam logic [STATE_BITS-1:0] S_DRAIN  = 3'd2;
  localparam logic [STATE_BITS-1:0] S_OUTPUT = 3'd3;
  localparam logic [STATE_BITS-1:0] S_DONE   = 3'd4;

  // Sample RAMs return data this many cycles after rd_en.
  localparam int RD_LAT = 1;

endpackage

// File: rtl/caf_shift_sched_if.sv
// Bundle of control, buffer-read, engine and result-stream signals around the lag sequencer.
interface caf_shift_sched_if #(
  parameter int ADDR_BITS  = 4,
  parameter int I_BITS     = 24,
  parameter int Q_BITS     = 24,
  parameter int SHIFT_BITS = 3
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_BITS-1:0]  ref_addr;
  logic [ADDR_BITS-1:0]  rx_addr;
  logic                  dp_x_tvalid;
  logic                  dp_y_tvalid;
  logic                  dp_tready;
  logic                  dp_tvalid;
  logic [I_BITS-1:0]     dp_i;
  logic [Q_BITS-1:0]     dp_q;
  logic                  out_tvalid;
  logic                  out_tready;
  logic [I_BITS-1:0]     out_i;
  logic [Q_BITS-1:0]     out_q;
  logic [SHIFT_BITS-1:0] out_shift;
  logic                  out_tlast;

  modport master (
    input  start, dp_tvalid, dp_i, dp_q, out_tready,
    output busy, done, rd_en, ref_addr, rx_addr,
           dp_x_tvalid, dp_y_tvalid, dp_tready,
           out_tvalid, out_i, out_q, out_shift, out_tlast
  );

  modport slave (
    output start, dp_tvalid, dp_i, dp_q, out_tready,
    input  busy, done, rd_en, ref_addr, rx_addr,
           dp_x_tvalid, dp_y_tvalid, dp_tready,
           out_tvalid, out_i, out_q, out_shift, out_tlast
  );
endinterface

// File: rtl/caf_addr_gen.sv
// Sample and lag counters for the sweep; produces the paired ref/rx buffer read addresses.
module caf_addr_gen
  import caf_pkg::*;
#(
  parameter int LENGTH     = 5,
  parameter int LEN_BITS   = 3,
  parameter int NUM_SHIFTS = 8,
  parameter int SHIFT_BITS = 3,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  issue_i,
  input  logic                  lag_inc_i,
  output logic                  rd_en_o,
  output logic [ADDR_BITS-1:0]  ref_addr_o,
  output logic [ADDR_BITS-1:0]  rx_addr_o,
  output logic [SHIFT_BITS-1:0] lag_o,
  output logic                  smp_last_o,
  output logic                  lag_last_o
);

  logic [LEN_BITS-1:0]   smp_q, smp_d;
  logic [SHIFT_BITS-1:0] lag_q, lag_d;

  assign smp_last_o = (smp_q == LEN_BITS'(LENGTH - 1));
  assign lag_last_o = (lag_q == SHIFT_BITS'(NUM_SHIFTS - 1));
  assign lag_o      = lag_q;
  assign rd_en_o    = issue_i;

  // Addresses are forced to zero outside the issue window so idle outputs stay quiet.
  assign ref_addr_o = issue_i ? ADDR_BITS'(smp_q) : '0;
  assign rx_addr_o  = issue_i ? ADDR_BITS'(lag_q) + ADDR_BITS'(smp_q) : '0;

  always_comb begin
    smp_d = smp_q;
    lag_d = lag_q;
    if (clr_i) begin
      smp_d = '0;
      lag_d = '0;
    end else begin
      if (issue_i) smp_d = smp_last_o ? '0 : smp_q + LEN_BITS'(1);
      if (lag_inc_i) lag_d = lag_q + SHIFT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
      lag_q <= '0;
    end else begin
      smp_q <= smp_d;
      lag_q <= lag_d;
    end
  end

endmodule

// File: rtl/caf_shift_sched.sv
// Lag-sweep sequencer for the complex dot-product engine; one tagged result per lag.
//   state  | meaning
//   IDLE   | waiting for start
//   ISSUE  | LENGTH buffer reads for the current lag
//   DRAIN  | engine flushing, wait for its result
//   OUTPUT | result held on the stream until accepted
//   DONE   | one-cycle completion pulse
module caf_shift_sched
  import caf_pkg::*;
#(
  parameter int LENGTH     = 5,
  parameter int LEN_BITS   = 3,
  parameter int NUM_SHIFTS = 8,
  parameter int SHIFT_BITS = 3,
  parameter int ADDR_BITS  = 4,
  parameter int I_BITS     = 24,
  parameter int Q_BITS     = 24
) (
  input logic               clk,
  input logic               rst_n,
  caf_shift_sched_if.master bus
);

  logic [STATE_BITS-1:0] state_q, state_d;
  logic                  clr, lag_inc, smp_last, lag_last, rd_en, issue;
  logic                  capture, handshake;
  logic [SHIFT_BITS-1:0] lag;
  logic [RD_LAT-1:0]     vld_pipe_q;
  logic                  out_tvalid_q;
  logic [I_BITS-1:0]     out_i_q;
  logic [Q_BITS-1:0]     out_q_q;
  logic [SHIFT_BITS-1:0] out_shift_q;

  assign issue     = (state_q == S_ISSUE);
  assign capture   = (state_q == S_DRAIN) && bus.dp_tvalid;
  assign handshake = (state_q == S_OUTPUT) && bus.out_tready;

  caf_addr_gen #(
    .LENGTH     (LENGTH),
    .LEN_BITS   (LEN_BITS),
    .NUM_SHIFTS (NUM_SHIFTS),
    .SHIFT_BITS (SHIFT_BITS),
    .ADDR_BITS  (ADDR_BITS)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .issue_i    (issue),
    .lag_inc_i  (lag_inc),
    .rd_en_o    (rd_en),
    .ref_addr_o (bus.ref_addr),
    .rx_addr_o  (bus.rx_addr),
    .lag_o      (lag),
    .smp_last_o (smp_last),
    .lag_last_o (lag_last)
  );

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    lag_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ISSUE;
          clr     = 1'b1;
        end
      end
      S_ISSUE:  if (smp_last) state_d = S_DRAIN;
      S_DRAIN:  if (bus.dp_tvalid) state_d = S_OUTPUT;
      S_OUTPUT: begin
        if (bus.out_tready) begin
          if (lag_last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            lag_inc = 1'b1;
          end
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vld_pipe_q   <= '0;
      out_tvalid_q <= 1'b0;
      out_i_q      <= '0;
      out_q_q      <= '0;
      out_shift_q  <= '0;
    end else begin
      state_q    <= state_d;
      vld_pipe_q <= (vld_pipe_q << 1) | RD_LAT'(rd_en);
      if (capture) begin
        out_i_q      <= bus.dp_i;
        out_q_q      <= bus.dp_q;
        out_shift_q  <= lag;
        out_tvalid_q <= 1'b1;
      end else if (handshake) begin
        out_tvalid_q <= 1'b0;
      end
    end
  end

  // Engine only advances while samples are in flight, so a stalled result never overruns it.
  assign bus.dp_tready   = issue || (state_q == S_DRAIN);
  assign bus.rd_en       = rd_en;
  assign bus.dp_x_tvalid = vld_pipe_q[RD_LAT-1];
  assign bus.dp_y_tvalid = vld_pipe_q[RD_LAT-1];
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.out_tvalid  = out_tvalid_q;
  assign bus.out_i       = out_i_q;
  assign bus.out_q       = out_q_q;
  assign bus.out_shift   = out_shift_q;
  assign bus.out_tlast   = out_tvalid_q && (out_shift_q == SHIFT_BITS'(NUM_SHIFTS - 1));

endmodule

// File: tb/tb_caf_shift_sched.sv
// Bench for caf_shift_sched: 1-cycle sample RAMs, a pipelined dot-product engine model, directed sweeps.
module tb_caf_shift_sched;

  localparam int LENGTH  = 5;
  localparam int ENG_LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  caf_shift_sched_if #(.ADDR_BITS(4), .I_BITS(24), .Q_BITS(24), .SHIFT_BITS(3)) bus ();
  caf_shift_sched_if #(.ADDR_BITS(4), .I_BITS(24), .Q_BITS(24), .SHIFT_BITS(1)) bus_b ();

  caf_shift_sched #(
    .LENGTH(5), .LEN_BITS(3), .NUM_SHIFTS(8), .SHIFT_BITS(3),
    .ADDR_BITS(4), .I_BITS(24), .Q_BITS(24)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  caf_shift_sched #(
    .LENGTH(5), .LEN_BITS(3), .NUM_SHIFTS(1), .SHIFT_BITS(1),
    .ADDR_BITS(4), .I_BITS(24), .Q_BITS(24)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // ---------------- sample RAMs and engine model for dut ----------------
  int ref_i [16];
  int ref_q [16];
  int rx_i  [16];
  int rx_q  [16];
  int ref_rd_i = 0, ref_rd_q = 0, rx_rd_i = 0, rx_rd_q = 0;
  int pr_i, pr_q;
  int acc_i, acc_q, n_smp, lat_cnt, eng_i, eng_q;
  logic eng_vld;
  logic spur_vld = 1'b0;
  int   spur_i = 0;

  always @(posedge clk) begin
    if (bus.rd_en) begin
      ref_rd_i <= ref_i[bus.ref_addr];
      ref_rd_q <= ref_q[bus.ref_addr];
      rx_rd_i  <= rx_i[bus.rx_addr];
      rx_rd_q  <= rx_q[bus.rx_addr];
    end
  end

  assign pr_i = ref_rd_i * rx_rd_i - ref_rd_q * rx_rd_q;
  assign pr_q = ref_rd_i * rx_rd_q + ref_rd_q * rx_rd_i;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_i <= 0; acc_q <= 0; n_smp <= 0; lat_cnt <= 0;
      eng_i <= 0; eng_q <= 0; eng_vld <= 1'b0;
    end else begin
      eng_vld <= 1'b0;
      if (bus.dp_tready) begin
        if (lat_cnt == 1) eng_vld <= 1'b1;
        if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
        if (bus.dp_x_tvalid && bus.dp_y_tvalid) begin
          if (n_smp == LENGTH - 1) begin
            eng_i <= acc_i + pr_i;
            eng_q <= acc_q + pr_q;
            acc_i <= 0; acc_q <= 0; n_smp <= 0;
            lat_cnt <= ENG_LAT;
          end else begin
            acc_i <= acc_i + pr_i;
            acc_q <= acc_q + pr_q;
            n_smp <= n_smp + 1;
          end
        end
      end
    end
  end

  assign bus.dp_tvalid = eng_vld | spur_vld;
  assign bus.dp_i      = spur_vld ? 24'(spur_i) : 24'(eng_i);
  assign bus.dp_q      = 24'(eng_q);

  // ---------------- monitor ----------------
  int addr_q [$];
  int done_total = 0;

  always @(negedge clk) begin
    if (bus.rd_en) addr_q.push_back(int'(bus.ref_addr) * 256 + int'(bus.rx_addr));
    if (bus.done) done_total <= done_total + 1;
  end

  // ---------------- checking helpers ----------------
  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endfunction

  task automatic wait_out(input string nm);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.out_tvalid && c < 300);
    if (!bus.out_tvalid) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic load(input int mode);
    for (int k = 0; k < 16; k++) begin
      ref_i[k] = 1; ref_q[k] = 0;
      rx_i[k]  = (mode == 0) ? 1 : k;
      rx_q[k]  = 0;
    end
  endtask

  function automatic int ctl_word();
    return int'({bus.busy, bus.done, bus.rd_en, bus.ref_addr, bus.rx_addr,
                 bus.dp_x_tvalid, bus.dp_y_tvalid, bus.dp_tready,
                 bus.out_tvalid, bus.out_tlast, bus.out_shift});
  endfunction

  typedef struct {
    int mode;
    int shift;
    int exp_i;
    int exp_q;
    int exp_last;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad, rd_ptr, base, res, cnt, got;
    int stall_bad, stall_rd, stall_rdy;

    bus.start = 1'b0; bus.out_tready = 1'b0;
    bus_b.start = 1'b0; bus_b.out_tready = 1'b0;
    bus_b.dp_tvalid = 1'b0; bus_b.dp_i = '0; bus_b.dp_q = '0;

    for (int s = 0; s < 8; s++) begin
      vecs[s]     = '{mode: 0, shift: s, exp_i: 5,          exp_q: 0, exp_last: int'(s == 7)};
      vecs[8 + s] = '{mode: 1, shift: s, exp_i: 5 * s + 10, exp_q: 0, exp_last: int'(s == 7)};
    end

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ctl", ctl_word(), 0);
    chk("rst_out_i", int'(bus.out_i), 0);
    chk("rst_out_q", int'(bus.out_q), 0);
    chk("rst_b_ctl", int'({bus_b.busy, bus_b.done, bus_b.rd_en, bus_b.out_tvalid}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven sweeps: all-ones, then ramp rx
    bus.out_tready = 1'b1;
    rd_ptr = 0;
    base = 0;
    for (int v = 0; v < 16; v++) begin
      if (v % 8 == 0) begin
        load(vecs[v].mode);
        rd_ptr = addr_q.size();
        base = done_total;
        pulse_start();
      end
      wait_out("vec_out");
      chk("vec_out_i", int'(bus.out_i), vecs[v].exp_i);
      chk("vec_out_q", int'(bus.out_q), vecs[v].exp_q);
      chk("vec_out_shift", int'(bus.out_shift), vecs[v].shift);
      chk("vec_out_tlast", int'(bus.out_tlast), vecs[v].exp_last);
      bad = 0;
      if (addr_q.size() != rd_ptr + LENGTH) bad = 100;
      else
        for (int j = 0; j < LENGTH; j++)
          if (addr_q[rd_ptr + j] != j * 256 + vecs[v].shift + j) bad++;
      rd_ptr = addr_q.size();
      chk("vec_addr_seq", bad, 0);
      if (v % 8 == 7) begin
        repeat (4) @(negedge clk);
        chk("sweep_done_pulses", done_total - base, 1);
        chk("sweep_busy_after", int'(bus.busy), 0);
      end
    end

    // stall at lag 3 with a stray engine valid that must be ignored
    load(1);
    base = done_total;
    pulse_start();
    for (int s = 0; s < 3; s++) wait_out("stall_pre");
    @(negedge clk);
    bus.out_tready = 1'b0;
    wait_out("stall_out");
    chk("stall_first_i", int'(bus.out_i), 25);
    chk("stall_first_shift", int'(bus.out_shift), 3);
    stall_bad = 0; stall_rd = 0; stall_rdy = 0;
    for (int c = 0; c < 20; c++) begin
      if (!bus.out_tvalid || bus.out_i != 24'd25 || bus.out_shift != 3'd3) stall_bad++;
      if (bus.rd_en) stall_rd++;
      if (bus.dp_tready) stall_rdy++;
      spur_vld = (c == 5);
      spur_i = 999;
      @(negedge clk);
    end
    spur_vld = 1'b0;
    chk("stall_out_stable", stall_bad, 0);
    chk("stall_rd_en", stall_rd, 0);
    chk("stall_dp_tready", stall_rdy, 0);
    bus.out_tready = 1'b1;
    got = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.rd_en) begin got = 1; break; end
    end
    chk("release_rd_en_seen", got, 1);
    chk("release_rx_addr", int'(bus.rx_addr), 4);
    chk("release_ref_addr", int'(bus.ref_addr), 0);
    for (int s = 4; s < 8; s++) wait_out("stall_post");
    chk("stall_last_i", int'(bus.out_i), 45);
    chk("stall_last_tlast", int'(bus.out_tlast), 1);
    repeat (4) @(negedge clk);
    chk("stall_done_pulses", done_total - base, 1);

    // start pokes while busy and during DONE
    load(0);
    base = done_total;
    res = 0;
    pulse_start();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.out_tvalid) res++;
      bus.start = (bus.busy && (c % 7 == 3)) || bus.done;
    end
    bus.start = 1'b0;
    chk("poke_results", res, 8);
    chk("poke_done_pulses", done_total - base, 1);
    chk("poke_busy_after", int'(bus.busy), 0);

    // reset in the middle of lag 2 issue
    load(1);
    pulse_start();
    got = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.rd_en && bus.rx_addr == 4'd3 && bus.ref_addr == 4'd1) begin got = 1; break; end
    end
    chk("midrst_reached_lag2", got, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctl", ctl_word(), 0);
    chk("midrst_out_i", int'(bus.out_i), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    wait_out("midrst_out");
    chk("midrst_restart_i", int'(bus.out_i), 10);
    chk("midrst_restart_shift", int'(bus.out_shift), 0);
    got = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.done) begin got = 1; break; end
    end
    chk("midrst_sweep_done", got, 1);
    bus.out_tready = 1'b0;

    // single-lag build: bench plays the engine by hand
    @(negedge clk);
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus_b.rd_en) cnt++;
      else if (cnt > 0) break;
      @(negedge clk);
    end
    chk("b_rd_en_count", cnt, 5);
    bus_b.dp_tvalid = 1'b1;
    bus_b.dp_i = 24'd5;
    @(negedge clk);
    bus_b.dp_tvalid = 1'b0;
    chk("b_out_tvalid", int'(bus_b.out_tvalid), 1);
    chk("b_out_tlast", int'(bus_b.out_tlast), 1);
    chk("b_out_shift", int'(bus_b.out_shift), 0);
    chk("b_out_i", int'(bus_b.out_i), 5);
    chk("b_done_early", int'(bus_b.done), 0);
    bus_b.out_tready = 1'b1;
    @(negedge clk);
    bus_b.out_tready = 1'b0;
    chk("b_done_pulse", int'(bus_b.done), 1);
    chk("b_out_tvalid_cleared", int'(bus_b.out_tvalid), 0);
    @(negedge clk);
    chk("b_done_one_cycle", int'(bus_b.done), 0);
    chk("b_busy_after", int'(bus_b.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
